// File: rtl/shared_port_sched.sv
// Shared-port scheduler: four requesters, LRU arbitration, bounded tenures.
// Grants are registered; each tenure is followed by a RELEASE and an IDLE cycle.
module shared_port_sched #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t          state, state_nx;
    logic [3:0][1:0] lru, lru_nx;
    logic [7:0]      hold, hold_nx;
    logic [3:0]      grant_nx;
    logic [1:0]      owner_nx;
    logic            timeout_nx;

    logic            found;
    logic [1:0]      win_pos;
    logic [1:0]      winner;
    logic            owner_done;
    logic            owner_idle;
    logic            at_limit;

    assign busy       = |grant;
    assign owner_done = done[owner];
    assign owner_idle = !req[owner];
    assign at_limit   = (hold == HOLD_LAST);

    // Walk the LRU list from the least recently granted entry.
    always_comb begin
        found   = 1'b0;
        win_pos = 2'd0;
        winner  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[lru[i]]) begin
                found   = 1'b1;
                win_pos = 2'(i);
                winner  = lru[i];
            end
        end
    end

    always_comb begin
        state_nx   = state;
        lru_nx     = lru;
        hold_nx    = hold;
        grant_nx   = grant;
        owner_nx   = owner;
        timeout_nx = 1'b0;
        unique case (state)
            IDLE: begin
                grant_nx = 4'd0;
                if (enable && found) begin
                    state_nx = GRANT;
                    grant_nx = 4'(1) << winner;
                    owner_nx = winner;
                    hold_nx  = 8'd0;
                    for (int i = 0; i < 3; i++) begin
                        if (i >= int'(win_pos)) lru_nx[i] = lru[i+1];
                    end
                    lru_nx[3] = winner;
                end
            end
            GRANT: begin
                hold_nx = hold + 8'd1;
                if (owner_done || owner_idle || at_limit) begin
                    state_nx   = RELEASE;
                    grant_nx   = 4'd0;
                    // Only a pure hold-limit exit counts as a timeout.
                    timeout_nx = at_limit && !owner_done && !owner_idle;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                grant_nx = 4'd0;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lru[0]  <= 2'd0;
            lru[1]  <= 2'd1;
            lru[2]  <= 2'd2;
            lru[3]  <= 2'd3;
            hold    <= 8'd0;
            grant   <= 4'd0;
            owner   <= 2'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            lru     <= lru_nx;
            hold    <= hold_nx;
            grant   <= grant_nx;
            owner   <= owner_nx;
            timeout <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_shared_port_sched.sv
// Directed bench for shared_port_sched: LRU order, hold limit,
// done filtering, enable gating and mid-tenure reset.
module tb_shared_port_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    shared_port_sched #(.MAX_HOLD(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        req    = 4'd0;
        done   = 4'd0;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (grant !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_grant: got %b want 0000", grant);
        end
        n_checks++;
        if (owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_owner: got %0d want 0", owner);
        end
        n_checks++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b timeout=%b want 0 0", busy, timeout);
        end
    endtask

    // Each owner drops req after one grant cycle: 0,1,2,3,0 with 2-cycle gaps.
    task automatic test_round_robin();
        logic [3:0] exp_g;
        int exp_o [5] = '{0, 1, 2, 3, 0};
        enable = 1'b1;
        req    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'(1) << exp_o[k];
            step();
            n_checks++;
            if (grant !== exp_g || owner !== 2'(exp_o[k]) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: grant=%b owner=%0d busy=%b want %b %0d 1",
                         k, grant, owner, busy, exp_g, exp_o[k]);
            end
            req = 4'b1111 & ~exp_g;
            step();
            n_checks++;
            if (grant !== 4'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_release%0d: grant=%b busy=%b timeout=%b want 0000 0 0",
                         k, grant, busy, timeout);
            end
            req = 4'b1111;
            step();
            n_checks++;
            if (grant !== 4'd0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: grant=%b want 0000", k, grant);
            end
        end
        req = 4'd0;
        step();
    endtask

    // LRU now 1,2,3,0. Requester 2 holds for the full limit and times out.
    task automatic test_timeout();
        int held = 0;
        req = 4'b0100;
        step();
        if (grant === 4'b0100) held++;
        for (int i = 1; i < 16; i++) begin
            step();
            if (grant === 4'b0100 && timeout === 1'b0) held++;
        end
        n_checks++;
        if (held != 16) begin
            n_fail++;
            $display("FAIL to_hold: held %0d cycles want 16", held);
        end
        step();
        n_checks++;
        if (grant !== 4'd0 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_pulse: grant=%b timeout=%b want 0000 1", grant, timeout);
        end
        step();
        n_checks++;
        if (grant !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle: grant=%b timeout=%b want 0000 0", grant, timeout);
        end
        step();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_regrant: grant=%b want 0100", grant);
        end
        req = 4'd0;
        step();
        n_checks++;
        if (grant !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_drop: grant=%b timeout=%b want 0000 0", grant, timeout);
        end
        step();
    endtask

    // LRU now 1,3,0,2. Only the owner's done bit may end the tenure.
    task automatic test_done_filter();
        req = 4'b0010;
        step();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL df_grant: grant=%b want 0010", grant);
        end
        done = 4'b1000;
        step();
        done = 4'd0;
        step();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL df_ignore: grant=%b want 0010", grant);
        end
        done = 4'b0010;
        step();
        n_checks++;
        if (grant !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL df_release: grant=%b timeout=%b want 0000 0", grant, timeout);
        end
        done = 4'd0;
        req  = 4'd0;
        step();
    endtask

    // LRU now 3,0,2,1. Dropping enable neither ends nor follows a tenure.
    task automatic test_enable_hold();
        int stray = 0;
        req = 4'b1000;
        step();
        n_checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            n_fail++;
            $display("FAIL en_grant: grant=%b owner=%0d want 1000 3", grant, owner);
        end
        enable = 1'b0;
        req    = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step();
            if (grant !== 4'b1000) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL en_keep: %0d cycles without grant 1000", stray);
        end
        done = 4'b1000;
        step();
        done  = 4'd0;
        req   = 4'b0001;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (grant !== 4'd0) stray++;
            step();
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL en_block: %0d cycles with grant while disabled", stray);
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL en_resume: grant=%b want 0001", grant);
        end
        req = 4'd0;
        step();
        step();
    endtask

    // Reset mid-tenure clears grant and restores LRU to 0,1,2,3.
    task automatic test_reset_mid();
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL rm_grant: grant=%b want 0100", grant);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_clear: grant=%b busy=%b timeout=%b want 0000 0 0",
                     grant, busy, timeout);
        end
        reset = 1'b0;
        req   = 4'b1100;
        step();
        n_checks++;
        if (grant !== 4'b0100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL rm_lru: grant=%b owner=%0d want 0100 2", grant, owner);
        end
        req = 4'd0;
        step();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_timeout: timeout=%b want 0", timeout);
        end
        step();
    endtask

    // LRU now 0,1,3,2. done coincides with the hold limit: no timeout.
    task automatic test_done_at_limit();
        int held = 0;
        req = 4'b0001;
        step();
        if (grant === 4'b0001) held++;
        for (int i = 1; i < 16; i++) begin
            step();
            if (grant === 4'b0001) held++;
        end
        n_checks++;
        if (held != 16) begin
            n_fail++;
            $display("FAIL dl_hold: held %0d cycles want 16", held);
        end
        done = 4'b0001;
        step();
        n_checks++;
        if (grant !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL dl_release: grant=%b timeout=%b want 0000 0", grant, timeout);
        end
        done = 4'd0;
        req  = 4'd0;
        step();
        n_checks++;
        if (grant !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL dl_idle: grant=%b timeout=%b want 0000 0", grant, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_done_filter();
        test_enable_hold();
        test_reset_mid();
        test_done_at_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
